// File: rtl/sid_filter_sched.sv
// sid_filter_sched: multi-cycle SID state-variable filter update sequenced over one shared multiplier
module sid_filter_sched #(
  parameter int FC_OFFSET = 64,
  parameter int RES_STEP  = 10,
  parameter int OUT_MAX   = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [11:0] v_0,
  input  logic [11:0] v_1,
  input  logic [11:0] v_2,
  input  logic [10:0] reg_fc,
  input  logic [3:0]  reg_res,
  input  logic [2:0]  reg_en,
  input  logic        reg_off3,
  input  logic        reg_hp,
  input  logic        reg_bp,
  input  logic        reg_lp,
  input  logic [3:0]  reg_vol,
  output logic        mul_req,
  input  logic        mul_gnt,
  output logic [31:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [47:0] mul_p,
  output logic [15:0] audio_out,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_MIX   = 4'd1;
  localparam logic [3:0] S_RES_I = 4'd2;
  localparam logic [3:0] S_RES_C = 4'd3;
  localparam logic [3:0] S_HP_I  = 4'd4;
  localparam logic [3:0] S_HP_C  = 4'd5;
  localparam logic [3:0] S_LP_I  = 4'd6;
  localparam logic [3:0] S_LP_C  = 4'd7;
  localparam logic [3:0] S_VOL_I = 4'd8;
  localparam logic [3:0] S_VOL_C = 4'd9;
  localparam logic [3:0] S_DONE  = 4'd10;

  logic [3:0]  state_q, state_d;
  logic [11:0] v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [10:0] fc_q, fc_d;
  logic [3:0]  res_q, res_d, vol_q, vol_d;
  logic [2:0]  en_q, en_d;
  logic        off3_q, off3_d, hp_q, hp_d, bp_q, bp_d, lp_q, lp_d;
  logic [31:0] low_q, low_d, band_q, band_d, high_q, high_d;
  logic [31:0] filt_q, filt_d, hn_q, hn_d, bn_q, bn_d;
  logic [15:0] osum_q, osum_d, pv_q, pv_d, audio_q, audio_d;
  logic        done_q, done_d, overrun_q, overrun_d;

  logic [13:0]        filt_sum, dir_sum;
  logic signed [35:0] out_sum;
  logic [15:0]        osum_clamp, fc_val, res_val;
  logic               granted, unused_bits;

  // Mix of the snapshot voices against the pre-update filter state, plus coefficients
  always_comb begin
    filt_sum = (en_q[0] ? {2'd0, v0_q} : 14'd0) + (en_q[1] ? {2'd0, v1_q} : 14'd0)
             + (en_q[2] ? {2'd0, v2_q} : 14'd0);
    dir_sum = (!en_q[0] ? {2'd0, v0_q} : 14'd0) + (!en_q[1] ? {2'd0, v1_q} : 14'd0)
            + (!en_q[2] && !off3_q ? {2'd0, v2_q} : 14'd0);
    out_sum = $signed({22'd0, dir_sum})
            + (lp_q ? 36'($signed(low_q)) : 36'sd0)
            + (bp_q ? 36'($signed(band_q)) : 36'sd0)
            + (hp_q ? 36'($signed(high_q)) : 36'sd0);
    osum_clamp = out_sum < 36'sd0 ? 16'd0 : out_sum > 36'(OUT_MAX) ? 16'(OUT_MAX) : out_sum[15:0];
    fc_val = 16'(fc_q) + 16'(FC_OFFSET);
    res_val = 16'd256 - 16'(res_q) * 16'(RES_STEP);
  end

  // Multiplier request and operands are driven only in the issue states, zero otherwise
  always_comb begin
    mul_req = state_q == S_RES_I || state_q == S_HP_I || state_q == S_LP_I || state_q == S_VOL_I;
    mul_a = state_q == S_RES_I ? band_q :
            state_q == S_HP_I  ? hn_q :
            state_q == S_LP_I  ? bn_q :
            state_q == S_VOL_I ? {16'd0, osum_q} : 32'd0;
    mul_b = state_q == S_RES_I ? res_val :
            (state_q == S_HP_I || state_q == S_LP_I) ? fc_val :
            state_q == S_VOL_I ? {12'd0, vol_q} : 16'd0;
    granted = mul_req && mul_gnt;
    busy = state_q != S_IDLE;
    done = done_q;
    overrun = overrun_q;
    audio_out = audio_q;
    unused_bits = ^mul_p[1:0];
  end

  // Sequencer: snapshot, mix, then RES/HP/LP/VOL as issue+capture pairs, then publish
  always_comb begin
    state_d = state_q;
    v0_d = v0_q;
    v1_d = v1_q;
    v2_d = v2_q;
    fc_d = fc_q;
    res_d = res_q;
    vol_d = vol_q;
    en_d = en_q;
    off3_d = off3_q;
    hp_d = hp_q;
    bp_d = bp_q;
    lp_d = lp_q;
    low_d = low_q;
    band_d = band_q;
    high_d = high_q;
    filt_d = filt_q;
    hn_d = hn_q;
    bn_d = bn_q;
    osum_d = osum_q;
    pv_d = pv_q;
    audio_d = audio_q;
    done_d = 1'b0;
    overrun_d = sample_en && busy;
    case (state_q)
      S_IDLE: if (sample_en) begin
        v0_d = v_0;
        v1_d = v_1;
        v2_d = v_2;
        fc_d = reg_fc;
        res_d = reg_res;
        vol_d = reg_vol;
        en_d = reg_en;
        off3_d = reg_off3;
        hp_d = reg_hp;
        bp_d = reg_bp;
        lp_d = reg_lp;
        state_d = S_MIX;
      end
      S_MIX: begin
        filt_d = {18'd0, filt_sum};
        osum_d = osum_clamp;
        state_d = S_RES_I;
      end
      S_RES_I: state_d = granted ? S_RES_C : S_RES_I;
      S_RES_C: begin
        hn_d = filt_q - low_q - mul_p[39:8];
        state_d = S_HP_I;
      end
      S_HP_I: state_d = granted ? S_HP_C : S_HP_I;
      S_HP_C: begin
        bn_d = band_q + mul_p[47:16];
        state_d = S_LP_I;
      end
      S_LP_I: state_d = granted ? S_LP_C : S_LP_I;
      S_LP_C: begin
        high_d = hn_q;
        band_d = bn_q;
        low_d = low_q + mul_p[47:16];
        state_d = S_VOL_I;
      end
      S_VOL_I: state_d = granted ? S_VOL_C : S_VOL_I;
      S_VOL_C: begin
        pv_d = mul_p[17:2];
        state_d = S_DONE;
      end
      S_DONE: begin
        audio_d = pv_q;
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any update in flight and clears the filter state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      v0_q <= '0;
      v1_q <= '0;
      v2_q <= '0;
      fc_q <= '0;
      res_q <= '0;
      vol_q <= '0;
      en_q <= '0;
      off3_q <= 1'b0;
      hp_q <= 1'b0;
      bp_q <= 1'b0;
      lp_q <= 1'b0;
      low_q <= '0;
      band_q <= '0;
      high_q <= '0;
      filt_q <= '0;
      hn_q <= '0;
      bn_q <= '0;
      osum_q <= '0;
      pv_q <= '0;
      audio_q <= '0;
      done_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      fc_q <= fc_d;
      res_q <= res_d;
      vol_q <= vol_d;
      en_q <= en_d;
      off3_q <= off3_d;
      hp_q <= hp_d;
      bp_q <= bp_d;
      lp_q <= lp_d;
      low_q <= low_d;
      band_q <= band_d;
      high_q <= high_d;
      filt_q <= filt_d;
      hn_q <= hn_d;
      bn_q <= bn_d;
      osum_q <= osum_d;
      pv_q <= pv_d;
      audio_q <= audio_d;
      done_q <= done_d;
      overrun_q <= overrun_d;
    end
  end
endmodule
